// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the IF/ID pipeline register.
// Define BRANCH_DELAY_SLOT_EN to keep the word fetched alongside a redirect (delay slot) instead of flushing it.
module fetch_stage #(
    parameter int unsigned INSTR_MEM_SIZE = 32,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic        o_misaligned,
    output logic [31:0] o_fetch_count
);

    localparam int unsigned W_ADDR = 32;

    logic [W_ADDR-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [W_ADDR-1:0] r_pc4;
    logic              r_valid;
    logic              r_misaligned;
    logic [31:0]       r_count;

    logic              w_in_range;
    logic [W_ADDR-1:0] w_pc_plus4;
    logic [W_ADDR-1:0] w_target;
    logic              w_target_misaligned;

    // Memory bound is checked on the word index so any byte offset in pc is irrelevant.
    assign w_in_range          = ({2'b00, r_pc[31:2]} < W_ADDR'(INSTR_MEM_SIZE));
    assign w_pc_plus4          = r_pc + W_ADDR'(4);
    assign w_target            = {i_redirect_pc[31:2], 2'b00};
    assign w_target_misaligned = (i_redirect_pc[1:0] != 2'b00);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_instr      <= 32'd0;
            r_pc4        <= 32'd0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_count      <= 32'd0;
        end else if (i_redirect) begin
            r_pc         <= w_target;
            r_misaligned <= r_misaligned | w_target_misaligned;
`ifdef BRANCH_DELAY_SLOT_EN
            // Delay slot: the word at the current pc is delivered like any normal fetch.
            r_pc4 <= w_pc_plus4;
            if (w_in_range) begin
                r_instr <= i_imem_data;
                r_valid <= 1'b1;
                r_count <= r_count + 32'd1;
            end else begin
                r_instr <= 32'd0;
                r_valid <= 1'b0;
            end
`else
            r_instr <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
`endif
        end else if (!i_stall) begin
            r_pc4 <= w_pc_plus4;
            if (w_in_range) begin
                r_pc    <= w_pc_plus4;
                r_instr <= i_imem_data;
                r_valid <= 1'b1;
                r_count <= r_count + 32'd1;
            end else begin
                r_instr <= 32'd0;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_if_id_instr = r_instr;
    assign o_if_id_pc4   = r_pc4;
    assign o_if_id_valid = r_valid;
    assign o_halted      = !w_in_range;
    assign o_misaligned  = r_misaligned;
    assign o_fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations plus
// randomized stall/redirect/reset traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned MEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
    logic        if_id_valid, halted, misaligned;

    logic [31:0] mem [0:MEM_WORDS-1];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(.INSTR_MEM_SIZE(MEM_WORDS), .RESET_PC(32'h0000_0000)) dut (
        .i_clock(clk), .i_reset(reset), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
        .o_pc(pc), .o_if_id_instr(if_id_instr), .o_if_id_pc4(if_id_pc4),
        .o_if_id_valid(if_id_valid), .o_halted(halted), .o_misaligned(misaligned),
        .o_fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory; beyond the array the bus returns garbage that must never reach IF/ID.
    always_comb begin
        if (imem_addr[31:2] < 30'(MEM_WORDS)) imem_data = mem[imem_addr[6:2]];
        else                                  imem_data = 32'hDEAD_BEEF;
    end

    // Behavioural model of the architectural state.
    logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_pc4 = 32'd0, m_cnt = 32'd0;
    logic        m_valid = 1'b0, m_mis = 1'b0;

    function automatic bit word_exists(input logic [31:0] a);
        return (a / 4) < MEM_WORDS;
    endfunction

    task automatic model_fetch_slot();
        m_pc4 = m_pc + 32'd4;
        if (word_exists(m_pc)) begin
            m_instr = mem[m_pc / 4];
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
        end else begin
            m_instr = 32'd0;
            m_valid = 1'b0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'd0;
        end else if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
            model_fetch_slot();
`else
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
`endif
            m_pc  = redirect_pc - (redirect_pc % 4);
            m_mis = m_mis || (redirect_pc % 4 != 0);
        end else if (!stall) begin
            logic was_in;
            was_in = word_exists(m_pc);
            model_fetch_slot();
            if (was_in) m_pc = m_pc + 32'd4;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc4", if_id_pc4, m_pc4);
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(!word_exists(m_pc)));
        check("misaligned", 32'(misaligned), 32'(m_mis));
        check("fetch_count", fetch_count, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_instr"}, if_id_instr, 32'h0);
        check({tag, "_pc4"}, if_id_pc4, 32'h0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_mis"}, 32'(misaligned), 32'h0);
        check({tag, "_cnt"}, fetch_count, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w [0:3];
        exp_w[0] = 32'h2001_0005; exp_w[1] = 32'h2002_0007;
        exp_w[2] = 32'h0022_1820; exp_w[3] = 32'hAC03_0000;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = exp_w[i];
        mem[4] = 32'h8C04_0004;

        // Sequential fetch of the first four words.
        do_reset();
        check_reset_vals("rst");
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("seq_instr%0d", i), if_id_instr, exp_w[i]);
            check($sformatf("seq_pc4_%0d", i), if_id_pc4, 32'(4 * (i + 1)));
        end
        check("seq_cnt", fetch_count, 32'd4);

        // Stall three cycles with pc=8.
        do_reset();
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h8);
            check("stall_instr", if_id_instr, 32'h2002_0007);
            check("stall_cnt", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        check("stall_resume", if_id_instr, 32'h0022_1820);
        check("stall_resume_cnt", fetch_count, 32'd3);

        // Redirect to 0x10 with pc=8.
        do_reset();
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        check("redir_pc", pc, 32'h10);
`ifdef BRANCH_DELAY_SLOT_EN
        check("redir_slot_instr", if_id_instr, 32'h0022_1820);
        check("redir_slot_valid", 32'(if_id_valid), 32'd1);
        check("redir_slot_cnt", fetch_count, 32'd3);
`else
        check("redir_flush_instr", if_id_instr, 32'h0);
        check("redir_flush_valid", 32'(if_id_valid), 32'd0);
        check("redir_flush_cnt", fetch_count, 32'd2);
`endif
        step();
        check("redir_target", if_id_instr, 32'h8C04_0004);
        check("redir_target_pc4", if_id_pc4, 32'h14);

        // Redirect+stall to a misaligned target; misaligned is sticky until reset.
        do_reset();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0006;
        step();
        stall = 1'b0; redirect = 1'b0;
        check("mis_pc", pc, 32'h4);
        check("mis_set", 32'(misaligned), 32'd1);
        step(); step(); step();
        check("mis_sticky", 32'(misaligned), 32'd1);
        do_reset();
        check("mis_cleared", 32'(misaligned), 32'd0);

        // Run off the end of memory.
        for (int i = 0; i < MEM_WORDS; i++) step();
        check("end_pc", pc, 32'h80);
        check("end_halted", 32'(halted), 32'd1);
        check("end_cnt", fetch_count, 32'd32);
        step();
        check("halt_pc_hold", pc, 32'h80);
        check("halt_valid", 32'(if_id_valid), 32'd0);
        check("halt_instr", if_id_instr, 32'h0);
        check("halt_pc4", if_id_pc4, 32'h84);
        check("halt_cnt", fetch_count, 32'd32);
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        check("unhalt", 32'(halted), 32'd0);
        check("unhalt_pc", pc, 32'h0);

        // Asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 8; i++) step();
        check("pre_async_pc", pc, 32'h20);
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        step();
        reset = 1'b0;

        // Randomized traffic checked by the per-cycle compare.
        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 32'($urandom_range(0, 32'h9F));
            if ($urandom_range(0, 19) == 0) redirect_pc = $urandom;
            step();
        end
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS CPU: holds the program counter, addresses the instruction memory, and registers the fetched word into the IF/ID pipeline register consumed by decode. It applies decode-stage stall and branch/jump redirect requests, suppresses fetch past the end of instruction memory, and counts delivered instructions for the lab benches.

## Interface
- INSTR_MEM_SIZE, 32, instruction memory depth in 32-bit words
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

- clock  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-high reset
- stall  input  1  decode hazard: hold PC and IF/ID
- redirect  input  1  branch taken / jump from decode
- redirect_pc  input  32  target byte address for redirect
- imem_addr  output  32  byte address to instruction memory (equals pc)
- imem_data  input  32  instruction word, combinational read of imem_addr[31:2]
- pc  output  32  current PC register
- if_id_instr  output  32  registered instruction to decode
- if_id_pc4  output  32  registered PC+4 of that instruction
- if_id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  PC is past end of instruction memory
- misaligned  output  1  sticky: a redirect target had bits [1:0] != 0
- fetch_count  output  32  number of instructions loaded into IF/ID with valid=1

## Operation
- Reset values: pc=RESET_PC, if_id_instr=0 (NOP), if_id_pc4=0, if_id_valid=0, halted=0, misaligned=0, fetch_count=0.
- in_range = (pc[31:2] < INSTR_MEM_SIZE); halted = !in_range (combinational from pc).
- Per rising edge, priority redirect > stall > normal:
  - redirect: pc <= {redirect_pc[31:2],2'b00}; misaligned <= misaligned | (redirect_pc[1:0]!=0); IF/ID per Configuration; stall ignored this cycle.
  - stall (no redirect): pc, IF/ID, fetch_count all hold.
  - normal, in_range: pc <= pc+4; if_id_instr <= imem_data; if_id_pc4 <= pc+4; if_id_valid <= 1; fetch_count <= fetch_count+1.
  - normal, !in_range: pc holds; if_id_instr <= 0; if_id_valid <= 0; if_id_pc4 <= pc+4; count holds.
- pc+4 wraps modulo 2^32; fetch_count wraps modulo 2^32.
- Leaving halted requires redirect to an in-range target or reset.

## Timing
- imem_addr = pc, combinational, no added latency; instruction at pc appears on if_id_* after the next rising edge (1-cycle latency).
- First edge after reset deasserts captures the word at RESET_PC.
- Redirect takes effect at the edge where it is sampled; target word reaches IF/ID one edge later.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of stall/redirect.
- Stall held N cycles freezes outputs N cycles; no instruction lost or duplicated.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: on redirect, IF/ID loads the currently fetched word (the delay slot) exactly as a normal in-range cycle (valid=1 if in_range, fetch_count increments); stall still ignored.
- Undefined: on redirect, IF/ID is flushed (if_id_instr=0, if_id_valid=0, if_id_pc4=0, fetch_count holds).

## Test plan
- Reset, RESET_PC=0, memory words 0..3 = 0x20010005, 0x20020007, 0x00221820, 0xAC030000, no stall/redirect -> after edges 1..4 if_id_instr shows those words in order, if_id_pc4 = 4,8,12,16, fetch_count=4.
- Stall high 3 cycles while pc=8 -> pc, if_id_instr=0x20020007, fetch_count hold 3 cycles, then resume with 0x00221820.
- Redirect to 0x10 while pc=8 -> next edge pc=0x10; without macro if_id_valid=0, instr=0; with macro if_id_instr=word 2; following edge if_id_instr=word 4.
- Redirect and stall same cycle, redirect_pc=0x0000_0006 -> pc=0x4, misaligned=1 and stays 1 until reset.
- INSTR_MEM_SIZE=32, run to pc=0x80 -> halted=1, pc holds 0x80, if_id_valid=0, fetch_count=32; redirect to 0 clears halted.
- Assert reset between edges with pc=0x20 -> all outputs return to reset values without a clock edge.
